// File: rtl/text_buffer_pkg.sv
// Shared definitions for the text-mode tile store: controller states and default geometry.
package text_buffer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StClear  = 2'd1,
        StScroll = 2'd2
    } tb_state_e;

    localparam int unsigned DefCols  = 80;
    localparam int unsigned DefRows  = 30;
    localparam int unsigned DefDataW = 7;

endpackage

// File: rtl/text_buffer_tile_ram.sv
// Simple dual-port tile RAM: one write port, one registered read-first read port, no array reset.
module text_buffer_tile_ram #(
    parameter int unsigned DEPTH  = 2400,
    parameter int unsigned DATA_W = 7,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_buffer.sv
// Text-mode tile store with circular row base, hardware clear and one-row scroll-up.
// The renderer read port stays live while a clear or scroll is running.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int unsigned       COLS   = DefCols,
    parameter int unsigned       ROWS   = DefRows,
    parameter int unsigned       DATA_W = DefDataW,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic                                  wr_en_i,
    input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] col_w_i,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_w_i,
    input  logic [DATA_W-1:0]                     din_i,
    output logic                                  wr_ready_o,
    input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] col_r_i,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_r_i,
    output logic [DATA_W-1:0]                     dout_o,
    input  logic                                  clear_i,
    input  logic                                  scroll_i,
    output logic                                  busy_o
);

    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so limits equal to 2**W still compare correctly.
    localparam logic [COL_W:0]   COL_LIM  = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    tb_state_e         state_q, state_d;
    logic [ROW_W-1:0]  base_q, base_d;
    logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              rd_valid_q;
    logic              rd_oor_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    logic              wr_in_range;
    logic              rd_in_range;

    // Logical (col,row) to physical address: rotate the row by base without a modulo.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row,
                                                    input logic [ROW_W-1:0] rbase);
        logic [ROW_W:0] phys;
        phys = {1'b0, row} + {1'b0, rbase};
        if (phys >= ROW_LIM) begin
            phys = phys - ROW_LIM;
        end
        return ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    assign wr_in_range = ({1'b0, col_w_i} < COL_LIM) && ({1'b0, row_w_i} < ROW_LIM);
    assign rd_in_range = ({1'b0, col_r_i} < COL_LIM) && ({1'b0, row_r_i} < ROW_LIM);
    assign ram_raddr   = rd_in_range ? tile_addr(col_r_i, row_r_i, base_q) : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StClear;
            base_q     <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            rd_valid_q <= 1'b1;
            rd_oor_q   <= ~rd_in_range;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        ram_we    = 1'b0;
        ram_waddr = tile_addr(col_w_i, row_w_i, base_q);
        ram_wdata = din_i;

        unique case (state_q)
            StIdle: begin
                ram_we = wr_en_i && wr_in_range;
                if (clear_i) begin
                    state_d   = StClear;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                    base_d    = '0;
                end else if (scroll_i) begin
                    state_d   = StScroll;
                    col_cnt_d = '0;
                end
            end

            StClear: begin
                ram_we    = 1'b1;
                ram_waddr = ADDR_W'(row_cnt_q) * ADDR_W'(COLS) + ADDR_W'(col_cnt_q);
                ram_wdata = FILL;
                if (col_cnt_q == COL_LAST) begin
                    col_cnt_d = '0;
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end else begin
                    col_cnt_d = col_cnt_q + COL_W'(1);
                end
            end

            StScroll: begin
                // The physical row at base is the old top row; it becomes the new bottom row.
                ram_we    = 1'b1;
                ram_waddr = ADDR_W'(base_q) * ADDR_W'(COLS) + ADDR_W'(col_cnt_q);
                ram_wdata = FILL;
                if (col_cnt_q == COL_LAST) begin
                    col_cnt_d = '0;
                    base_d    = (base_q == ROW_LAST) ? '0 : base_q + ROW_W'(1);
                    state_d   = StIdle;
                end else begin
                    col_cnt_d = col_cnt_q + COL_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    text_buffer_tile_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_tile_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign busy_o     = (state_q != StIdle);
    assign wr_ready_o = ~busy_o;
    assign dout_o     = !rd_valid_q ? '0 : (rd_oor_q ? FILL : ram_rdata);

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: a logical grid model (rows shift on scroll) checked against DUT reads.
module tb_text_buffer;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam logic [6:0] FILL = 7'd0;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic       wr_en = 1'b0;
    logic [6:0] col_w = '0;
    logic [4:0] row_w = '0;
    logic [6:0] din = '0;
    logic       wr_ready;
    logic [6:0] col_r = '0;
    logic [4:0] row_r = '0;
    logic [6:0] dout;
    logic       clear = 1'b0;
    logic       scroll = 1'b0;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic [6:0] grid [ROWS][COLS];

    text_buffer dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .wr_en_i    (wr_en),
        .col_w_i    (col_w),
        .row_w_i    (row_w),
        .din_i      (din),
        .wr_ready_o (wr_ready),
        .col_r_i    (col_r),
        .row_r_i    (row_r),
        .dout_o     (dout),
        .clear_i    (clear),
        .scroll_i   (scroll),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) grid[r][c] = FILL;
    endfunction

    function automatic void model_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) grid[r][c] = grid[r+1][c];
        for (int c = 0; c < COLS; c++) grid[ROWS-1][c] = FILL;
    endfunction

    // All driver tasks start and end just after a falling edge.
    task automatic do_write(input int c, input int r, input logic [6:0] d);
        int n;
        wr_en = 1'b1; col_w = 7'(c); row_w = 5'(r); din = d;
        n = 0;
        while (!wr_ready && n < 5000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int c, input int r, output logic [6:0] v);
        col_r = 7'(c); row_r = 5'(r);
        @(negedge clk);
        v = dout;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk); n++;
        end
    endtask

    task automatic pulse(input logic c, input logic s);
        clear = c; scroll = s;
        @(negedge clk);
        clear = 1'b0; scroll = 1'b0;
    endtask

    task automatic fill_random();
        logic [6:0] d;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                d = 7'($urandom_range(127, 1));
                do_write(c, r, d);
                grid[r][c] = d;
            end
    endtask

    task automatic test_reset();
        int n;
        logic [6:0] v;
        rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
        total++;
        if (dout !== 7'd0) begin bad++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        rstn_i = 1'b1;
        wait_idle(n);
        total++;
        if (n != COLS * ROWS) begin bad++; $display("FAIL reset_clear_len got=%0d exp=%0d", n, COLS * ROWS); end
        model_clear();
        do_read(0, 0, v);
        total++;
        if (v !== FILL) begin bad++; $display("FAIL reset_tile00 got=%0d exp=%0d", v, FILL); end
        do_read(COLS - 1, ROWS - 1, v);
        total++;
        if (v !== FILL) begin bad++; $display("FAIL reset_tile_last got=%0d exp=%0d", v, FILL); end
    endtask

    task automatic test_fill_readback();
        logic [6:0] v, oldv, d;
        int c, r;
        for (int k = COLS * ROWS - 1; k >= 0; k--) begin
            d = 7'(COLS * ROWS - 1 - k);
            do_write(k % COLS, k / COLS, d);
            grid[k / COLS][k % COLS] = d;
        end
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++) begin
                do_read(cc, rr, v);
                total++;
                if (v !== grid[rr][cc]) begin
                    bad++; $display("FAIL readback (%0d,%0d) got=%0d exp=%0d", cc, rr, v, grid[rr][cc]);
                end
            end
        for (int i = 0; i < 8; i++) begin
            c = $urandom_range(COLS - 1); r = $urandom_range(ROWS - 1);
            oldv = grid[r][c];
            d = oldv ^ 7'h55;
            wr_en = 1'b1; col_w = 7'(c); row_w = 5'(r); din = d;
            col_r = 7'(c); row_r = 5'(r);
            @(negedge clk);
            wr_en = 1'b0;
            v = dout;
            total++;
            if (v !== oldv) begin bad++; $display("FAIL read_first (%0d,%0d) got=%0d exp=%0d", c, r, v, oldv); end
            grid[r][c] = d;
            do_read(c, r, v);
            total++;
            if (v !== d) begin bad++; $display("FAIL read_after_write (%0d,%0d) got=%0d exp=%0d", c, r, v, d); end
        end
    endtask

    task automatic test_back_to_back();
        int ca[100];
        int ra[100];
        logic [6:0] v;
        for (int i = 0; i < 100; i++) begin
            ca[i] = $urandom_range(COLS - 1); ra[i] = $urandom_range(ROWS - 1);
        end
        col_r = 7'(ca[0]); row_r = 5'(ra[0]);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            v = dout;
            if (i < 100) begin col_r = 7'(ca[i]); row_r = 5'(ra[i]); end
            total++;
            if (v !== grid[ra[i-1]][ca[i-1]]) begin
                bad++; $display("FAIL b2b_read (%0d,%0d) got=%0d exp=%0d", ca[i-1], ra[i-1], v, grid[ra[i-1]][ca[i-1]]);
            end
        end
    endtask

    task automatic test_scroll();
        int n;
        logic [6:0] v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_write(c, r, 7'(r + 1));
                grid[r][c] = 7'(r + 1);
            end
        pulse(1'b0, 1'b1);
        wait_idle(n);
        total++;
        if (n != COLS) begin bad++; $display("FAIL scroll_len got=%0d exp=%0d", n, COLS); end
        model_scroll();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v);
                total++;
                if (v !== grid[r][c]) begin bad++; $display("FAIL scroll1 (%0d,%0d) got=%0d exp=%0d", c, r, v, grid[r][c]); end
            end
        for (int s = 1; s < ROWS; s++) begin
            pulse(1'b0, 1'b1);
            wait_idle(n);
            total++;
            if (n != COLS) begin bad++; $display("FAIL scroll_len_%0d got=%0d exp=%0d", s, n, COLS); end
            model_scroll();
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v);
                total++;
                if (v !== grid[r][c]) begin bad++; $display("FAIL scroll_wrap (%0d,%0d) got=%0d exp=%0d", c, r, v, grid[r][c]); end
            end
    endtask

    task automatic test_busy_ops();
        int n;
        logic [6:0] v;
        fill_random();
        do_write(3, 3, 7'd1); grid[3][3] = 7'd1;
        do_write(3, 4, 7'd9); grid[4][3] = 7'd9;
        pulse(1'b0, 1'b1);
        n = 0;
        while (busy && n < 5000) begin
            if (n == 5) begin wr_en = 1'b1; col_w = 7'd3; row_w = 5'd3; din = 7'd5; end
            if (n == 6) begin
                total++;
                if (wr_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", wr_ready); end
            end
            if (n == 10) begin clear = 1'b1; scroll = 1'b1; end
            if (n == 11) begin clear = 1'b0; scroll = 1'b0; wr_en = 1'b0; end
            @(negedge clk); n++;
        end
        wr_en = 1'b0; clear = 1'b0; scroll = 1'b0;
        total++;
        if (n != COLS) begin bad++; $display("FAIL busy_ignore_len got=%0d exp=%0d", n, COLS); end
        model_scroll();
        do_read(3, 3, v);
        total++;
        if (v !== grid[3][3]) begin bad++; $display("FAIL busy_write_drop got=%0d exp=%0d", v, grid[3][3]); end
        do_read(17, ROWS - 1, v);
        total++;
        if (v !== FILL) begin bad++; $display("FAIL busy_new_row got=%0d exp=%0d", v, FILL); end
        pulse(1'b1, 1'b1);
        wait_idle(n);
        total++;
        if (n != COLS * ROWS) begin bad++; $display("FAIL clear_wins_len got=%0d exp=%0d", n, COLS * ROWS); end
        model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v);
                total++;
                if (v !== grid[r][c]) begin bad++; $display("FAIL clear_grid (%0d,%0d) got=%0d exp=%0d", c, r, v, grid[r][c]); end
            end
    endtask

    task automatic test_out_of_range();
        int n;
        logic [6:0] v;
        fill_random();
        for (int s = 0; s < 3; s++) begin
            pulse(1'b0, 1'b1);
            wait_idle(n);
            model_scroll();
        end
        do_write(COLS, 0, 7'd9);
        do_write(0, ROWS, 7'd9);
        do_write(127, 31, 7'd9);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v);
                total++;
                if (v !== grid[r][c]) begin bad++; $display("FAIL oor_write (%0d,%0d) got=%0d exp=%0d", c, r, v, grid[r][c]); end
            end
        do_read(127, 0, v);
        total++;
        if (v !== FILL) begin bad++; $display("FAIL oor_read_col got=%0d exp=%0d", v, FILL); end
        do_read(0, 31, v);
        total++;
        if (v !== FILL) begin bad++; $display("FAIL oor_read_row got=%0d exp=%0d", v, FILL); end
        do_read(5, 4, v);
        total++;
        if (v !== grid[4][5]) begin bad++; $display("FAIL oor_then_valid got=%0d exp=%0d", v, grid[4][5]); end
    endtask

    task automatic test_reset_mid_scroll();
        int n;
        logic [6:0] v;
        pulse(1'b0, 1'b1);
        repeat (40) @(negedge clk);
        rstn_i = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy got=%b exp=1", busy); end
        total++;
        if (dout !== 7'd0) begin bad++; $display("FAIL midreset_dout got=%0d exp=0", dout); end
        repeat (3) @(negedge clk);
        rstn_i = 1'b1;
        wait_idle(n);
        total++;
        if (n != COLS * ROWS) begin bad++; $display("FAIL midreset_clear_len got=%0d exp=%0d", n, COLS * ROWS); end
        model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v);
                total++;
                if (v !== grid[r][c]) begin bad++; $display("FAIL midreset_grid (%0d,%0d) got=%0d exp=%0d", c, r, v, grid[r][c]); end
            end
        do_write(10, 10, 7'd33); grid[10][10] = 7'd33;
        pulse(1'b0, 1'b1);
        wait_idle(n);
        model_scroll();
        do_read(10, 9, v);
        total++;
        if (v !== grid[9][10]) begin bad++; $display("FAIL midreset_post_scroll got=%0d exp=%0d", v, grid[9][10]); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_readback();
        test_back_to_back();
        test_scroll();
        test_busy_ops();
        test_out_of_range();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
